cla8_add_sequencer: RTL and testbench
=====================================

CLA8_ADD_SEQUENCER -- requirements
Module: cla8_add_sequencer

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  start_valid  in  1  operation request
  start_ready  out  1  block can accept a request
  a  in  32  operand A
  b  in  32  operand B
  sub  in  1  0 = A+B, 1 = A-B
  result_valid  out  1  result available
  result_ready  in  1  consumer accepts result
  result  out  32  sum/difference
  cout  out  1  final carry (for sub, 1 = no borrow)
  ovf  out  1  signed overflow
  zero  out  1  result == 0
  cla_in1  out  8  byte to shared 8-bit CLA slice, input 1
  cla_in2  out  8  byte to shared 8-bit CLA slice, input 2
  cla_cin  out  1  carry into CLA slice
  cla_sum  in  8  CLA slice sum (combinational return)
  cla_cout  in  1  CLA slice carry out
REQ-002 The block SHALL have no parameters; widths are fixed at 32-bit operands and an 8-bit slice.

Function
REQ-003 The block SHALL compute a 32-bit add/subtract by sequencing one external 8-bit CLA slice over 4 cycles, least significant byte first.
REQ-004 FSM states SHALL be IDLE, RUN, DONE; a 2-bit byte index idx is valid in RUN.
REQ-005 start_ready SHALL be 1 only in IDLE; start_valid in RUN/DONE SHALL be ignored.
REQ-006 On a clk edge in IDLE with start_valid=1: latch opA=a, opB=(sub ? ~b : b), carry=sub, idx=0, clear result, go to RUN.
REQ-007 In RUN: cla_in1=opA[8*idx+7:8*idx], cla_in2=opB[8*idx+7:8*idx], cla_cin=carry, all combinational from registers.
REQ-008 Each RUN edge: result[8*idx+7:8*idx] <= cla_sum, carry <= cla_cout, idx <= idx+1.
REQ-009 On the RUN edge with idx=3: go to DONE, cout <= cla_cout, ovf <= (opA[31]==opB[31]) & (cla_sum[7]!=opA[31]).
REQ-010 Latency: result_valid SHALL rise exactly 4 clk edges after the accepting edge (first RUN cycle = cycle 1, DONE at cycle 5).
REQ-011 result_valid SHALL be 1 only in DONE; result, cout, ovf, zero SHALL be held stable while result_valid=1 and result_ready=0.
REQ-012 zero SHALL be combinational (result == 32'h0) and is meaningful only while result_valid=1.
REQ-013 On a DONE edge with result_ready=1: go to IDLE; result, cout, ovf keep their values until the next accept.
REQ-014 In IDLE and DONE, cla_in1, cla_in2, cla_cin SHALL be driven 0.
REQ-015 Arithmetic SHALL be modulo 2^32; the carry out of bit 31 is reported only through cout.
REQ-016 A new operation SHALL NOT be accepted in the same cycle DONE is left; the minimum issue interval is 6 cycles.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, idx=0, carry=0, opA/opB=0, result=0, cout=0, ovf=0, result_valid=0, start_ready=1, cla_* outputs=0.
REQ-018 Reset asserted during RUN or DONE SHALL discard the operation in progress; no partial result SHALL be presented after reset is released.
REQ-019 After rst_n rises, the first edge with start_valid=1 SHALL be accepted normally.

Verification
REQ-020 Add 0x000000FF + 0x00000001, sub=0 -> result=0x00000100, cout=0, ovf=0, zero=0, result_valid rises 4 edges after accept.
REQ-021 Add 0xFFFFFFFF + 0x00000001 -> result=0x00000000, cout=1, ovf=0, zero=1; the carry ripples through all 4 slice passes.
REQ-022 Sub 0x7FFFFFFF - 0xFFFFFFFF -> result=0x80000000, ovf=1, cout=0; sub 5 - 5 -> result=0, zero=1, cout=1.
REQ-023 Byte order: A=0x44332211, B=0 -> cla_in1 shows 0x11, 0x22, 0x33, 0x44 on RUN cycles 1 to 4, with cla_cin=0 throughout.
REQ-024 Backpressure: hold result_ready=0 for 3 cycles in DONE while start_valid=1 -> outputs stable, start_ready=0, no accept; then result_ready=1 -> IDLE, and the next request is accepted one edge later.
REQ-025 Assert rst_n=0 mid-clock during RUN with idx=2 -> all outputs reach their reset values without a clk edge; after release, A=1 + B=2 -> result=3.

Source files
------------

// File: rtl/cla8_add_sequencer.sv
// 32-bit add/subtract built by running one external 8-bit CLA slice over four
// cycles, least significant byte first; result is held until the consumer takes it.
module cla8_add_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        cout,
  output logic        ovf,
  output logic        zero,
  output logic [7:0]  cla_in1,
  output logic [7:0]  cla_in2,
  output logic        cla_cin,
  input  logic [7:0]  cla_sum,
  input  logic        cla_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_idx;
  logic        r_carry;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_result;
  logic        r_cout;
  logic        r_ovf;

  logic [4:0]  w_bit_base;
  logic        w_accept;

  assign w_bit_base   = {r_idx, 3'b000};
  assign w_accept     = (r_state == S_IDLE) && start_valid;

  assign start_ready  = (r_state == S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;
  assign cout         = r_cout;
  assign ovf          = r_ovf;
  assign zero         = (r_result == 32'h0);

  // The slice only sees operand bytes while running; otherwise it is parked at zero.
  always_comb begin
    cla_in1 = 8'h00;
    cla_in2 = 8'h00;
    cla_cin = 1'b0;
    if (r_state == S_RUN) begin
      cla_in1 = r_op_a[w_bit_base +: 8];
      cla_in2 = r_op_b[w_bit_base +: 8];
      cla_cin = r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_carry  <= 1'b0;
      r_op_a   <= 32'h0;
      r_op_b   <= 32'h0;
      r_result <= 32'h0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Subtraction is A + ~B + 1, so the inverted operand and the +1 are set up here.
            r_op_a   <= a;
            r_op_b   <= sub ? ~b : b;
            r_carry  <= sub;
            r_idx    <= 2'd0;
            r_result <= 32'h0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[w_bit_base +: 8] <= cla_sum;
          r_carry                   <= cla_cout;
          r_idx                     <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_cout  <= cla_cout;
            r_ovf   <= (r_op_a[31] == r_op_b[31]) && (cla_sum[7] != r_op_a[31]);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla8_add_sequencer.sv
// Bench for cla8_add_sequencer: models the 8-bit CLA slice and checks a vector
// table plus byte order, backpressure and mid-operation reset sequences.
module tb_cla8_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [7:0]  cla_in1;
  logic [7:0]  cla_in2;
  logic        cla_cin;
  logic [7:0]  cla_sum;
  logic        cla_cout;

  int checks = 0;
  int errors = 0;

  cla8_add_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .sub          (sub),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .cout         (cout),
    .ovf          (ovf),
    .zero         (zero),
    .cla_in1      (cla_in1),
    .cla_in2      (cla_in2),
    .cla_cin      (cla_cin),
    .cla_sum      (cla_sum),
    .cla_cout     (cla_cout)
  );

  // External slice: plain 8-bit adder with carry in/out.
  assign {cla_cout, cla_sum} = {1'b0, cla_in1} + {1'b0, cla_in2} + {8'h00, cla_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vsub;
    logic [31:0] exp_result;
    logic        exp_cout;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Ends at the negedge right after the accepting edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_in, input logic ts);
    @(negedge clk);
    check("start_ready_before_accept", {31'b0, start_ready}, 32'd1);
    a           = ta;
    b           = tb_in;
    sub         = ts;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume(input logic [31:0] exp_res);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    check("valid_low_after_consume", {31'b0, result_valid}, 32'd0);
    check("ready_high_after_consume", {31'b0, start_ready}, 32'd1);
    check("result_kept_in_idle", result, exp_res);
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

    rst_n        = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    a            = 32'h0;
    b            = 32'h0;
    sub          = 1'b0;

    #3;
    check("reset_start_ready", {31'b0, start_ready}, 32'd1);
    check("reset_result_valid", {31'b0, result_valid}, 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_cla_in1", {24'b0, cla_in1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vsub);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd4);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].exp_cout});
      check($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
      check($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].exp_zero});
      check($sformatf("v%0d_cla_idle_done", i), {23'b0, cla_cin, cla_in1}, 32'h0);
      consume(vecs[i].exp_result);
    end

    // Byte order: slice sees 0x11, 0x22, 0x33, 0x44 on successive RUN cycles.
    start_op(32'h44332211, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("byte%0d_cla_in1", k), {24'b0, cla_in1}, 32'h11 * (k + 1));
      check($sformatf("byte%0d_cla_cin", k), {31'b0, cla_cin}, 32'd0);
      check($sformatf("byte%0d_not_valid", k), {31'b0, result_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check("byte_done_valid", {31'b0, result_valid}, 32'd1);
    check("byte_done_result", result, 32'h44332211);

    // Backpressure: DONE holds while start_valid is also asserted.
    held        = result;
    a           = 32'd10;
    b           = 32'd20;
    sub         = 1'b0;
    start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", {31'b0, result_valid}, 32'd1);
      check("bp_start_ready_low", {31'b0, start_ready}, 32'd0);
      check("bp_result_stable", result, held);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    check("bp_leave_done_idle", {31'b0, start_ready}, 32'd1);
    check("bp_no_same_cycle_accept", {31'b0, result_valid}, 32'd0);
    check("bp_result_after_leave", result, held);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    check("bp_next_accepted", {31'b0, start_ready}, 32'd0);
    check("bp_next_run_byte0", {24'b0, cla_in1}, 32'd10);
    wait_done(lat);
    check("bp_next_latency", lat, 32'd4);
    check("bp_next_result", result, 32'd30);
    consume(32'd30);

    // Reset mid-clock during RUN with idx=2.
    start_op(32'h00AB0000, 32'h00CD0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_cla_in1_idx2", {24'b0, cla_in1}, 32'hAB);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_start_ready", {31'b0, start_ready}, 32'd1);
    check("rst_async_valid", {31'b0, result_valid}, 32'd0);
    check("rst_async_result", result, 32'h0);
    check("rst_async_flags", {30'b0, cout, ovf}, 32'h0);
    check("rst_async_cla", {15'b0, cla_cin, cla_in2, cla_in1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_no_partial_result", {31'b0, result_valid}, 32'd0);
    end
    start_op(32'd1, 32'd2, 1'b0);
    wait_done(lat);
    check("rst_after_latency", lat, 32'd4);
    check("rst_after_result", result, 32'd3);
    consume(32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
